branch_predict_ctrl: RTL and testbench
======================================

# branch_predict_ctrl

Branch resolution controller and 2-bit dynamic predictor for the RISC-V core. At fetch it supplies a taken/not-taken prediction from a table of saturating counters. At execute it takes the branch comparator's `should_branch` result and compares it with the prediction that travelled down the pipe. On a mispredict it issues a one-cycle PC redirect and holds the front-end flush for a fixed number of cycles.

## Interface

**Parameters**
- `IDX_BITS`, default 4: branch history table (BHT) has 2^IDX_BITS entries, indexed by `pc[IDX_BITS+1:2]`.
- `FLUSH_CYCLES`, default 2: number of cycles `flush` is held high after a mispredict; legal range 1..7.

**Ports**
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `fetch_valid` in 1: a fetch lookup is requested this cycle.
- `fetch_pc` in 32: PC being fetched.
- `predict_taken` out 1: prediction for `fetch_pc`; combinational, equals `fetch_valid & bht[idx(fetch_pc)][1]`.
- `ex_valid` in 1: the EX stage holds a valid instruction.
- `ex_is_branch` in 1: the EX instruction is a conditional branch.
- `ex_pc` in 32: PC of the EX instruction.
- `ex_target` in 32: computed branch target (`pc + imm`).
- `ex_pred_taken` in 1: prediction made at fetch for this instruction.
- `should_branch` in 1: actual outcome from the branch comparator.
- `redirect_valid` out 1: one-cycle pulse; the fetch PC must load `redirect_pc`.
- `redirect_pc` out 32: corrected PC.
- `flush` out 1: squash the IF/ID stages while high.
- `branch_count` out 16: resolved branches, saturating.
- `mispredict_count` out 16: mispredicts, saturating.

## Operation

- **Resolve event:** `ex_valid & ex_is_branch` while the state is IDLE. In FLUSH state the EX inputs are ignored, because they belong to squashed instructions.
- **Mispredict:** a resolve event with `should_branch != ex_pred_taken`.
  - If `should_branch` is 1, the corrected PC is `ex_target`.
  - If `should_branch` is 0, the corrected PC is `ex_pc + 4`, computed modulo 2^32; wrap-around is allowed.
- **BHT entries:** 2-bit counters.
  - On each resolve event, increment if `should_branch` is 1, otherwise decrement. Saturate at 3 and 0.
  - Only the entry at `idx(ex_pc)` is updated.
- **Read/write collision:** if a fetch lookup and an update hit the same index in one cycle, the lookup returns the pre-update value.
- **State machine, 2 states:**
  - IDLE → FLUSH on a mispredict. Load `flush_cnt = FLUSH_CYCLES - 1`, register `redirect_pc`, and pulse `redirect_valid`.
  - FLUSH: decrement `flush_cnt` each cycle. Return to IDLE on the cycle after `flush_cnt` reaches 0.
  - A correct prediction stays in IDLE with no redirect.
- **Counters:**
  - `branch_count` increments on every resolve event.
  - `mispredict_count` increments on every mispredict.
  - Both saturate at 16'hFFFF and never wrap.
- **Reset (`rst_n` = 0 at a clock edge):**
  - All BHT entries go to 2'b01 (weakly not-taken).
  - State goes to IDLE.
  - `redirect_valid`, `flush`, `redirect_pc`, `branch_count` and `mispredict_count` all go to 0.
  - `predict_taken` then reads 0.
  - Reset during FLUSH aborts the flush immediately.

## Timing

- Resolution inputs are sampled at edge E. `redirect_valid`, `redirect_pc` and `flush` are registered and become valid in the cycle after E.
- `redirect_valid` is high for exactly 1 cycle per mispredict.
- `flush` is high for exactly `FLUSH_CYCLES` consecutive cycles, starting in the same cycle as `redirect_valid`.
- A BHT update takes effect for lookups one cycle after the resolve edge.
- Counter values are visible the cycle after the event.
- Back-to-back resolve events in IDLE are each processed, one per cycle.
- A mispredict on the first IDLE cycle after a flush is accepted normally.
- `predict_taken` has zero latency: it is a purely combinational read of the registered table.

## Test plan

1. **Reset defaults.** Hold `rst_n` = 0 for 2 cycles, then release. Lookup `fetch_pc` = 0x100 with `fetch_valid` = 1 → `predict_taken` = 0; `redirect_valid`, `flush` and both counters = 0.
2. **Taken mispredict.** `ex_pc` = 0x200, `ex_target` = 0x180, `ex_pred_taken` = 0, `should_branch` = 1.
   - Next cycle: `redirect_valid` = 1 and `redirect_pc` = 0x180.
   - `flush` stays high for 2 cycles.
   - `mispredict_count` = 1, `branch_count` = 1.
   - During the flush, EX branch inputs are ignored and the counters are unchanged.
3. **Counter training and saturation.** Resolve `ex_pc` = 0x40 taken 3 times, with the prediction made correct after the first.
   - `predict_taken` for 0x40 becomes 1 after the first update, since the entry goes 01→10.
   - The entry then saturates at 3.
   - Two not-taken updates give 3→2→1, so the prediction reads 0.
   - Aliased PC 0x80 (IDX_BITS = 4) shares the entry.
4. **Not-taken mispredict with wrap.** `ex_pc` = 0xFFFFFFFC, `ex_pred_taken` = 1, `should_branch` = 0 → `redirect_pc` = 0x00000000.
5. **Read/write collision.** Same-cycle lookup of 0x40 and a taken update of 0x40 from an entry of 01 → `predict_taken` = 0 in that cycle and 1 in the next.
6. **Reset mid-flush and counter saturation.**
   - With FLUSH_CYCLES = 4, assert `rst_n` = 0 in the 2nd flush cycle → `flush` = 0 on the next cycle and the state is IDLE.
   - Separately, preload 0xFFFF resolves (or force the counters) → both counters stay at 0xFFFF after further events.

Source files
------------

// File: rtl/branch_predict_ctrl.sv
// branch_predict_ctrl: 2-bit saturating-counter branch predictor plus branch
// resolution with one-cycle PC redirect and a fixed-length front-end flush.
module branch_predict_ctrl #(
  parameter int IDX_BITS     = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_pc,
  output logic        predict_taken,
  input  logic        ex_valid,
  input  logic        ex_is_branch,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic        should_branch,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        flush,
  output logic [15:0] branch_count,
  output logic [15:0] mispredict_count
);
  localparam int N = 1 << IDX_BITS;
  typedef enum logic {IDLE, FLUSH} state_e;
  state_e              state_q, state_d;
  logic [1:0]          bht_q [N];
  logic [1:0]          upd_d;
  logic [2:0]          flush_cnt_q, flush_cnt_d;
  logic                redirect_valid_q, redirect_valid_d;
  logic [31:0]         redirect_pc_q, redirect_pc_d;
  logic [15:0]         branch_count_q, branch_count_d;
  logic [15:0]         mispredict_count_q, mispredict_count_d;
  logic [IDX_BITS-1:0] fetch_idx, ex_idx;
  logic                resolve, mispredict;
  logic                unused_bits;
  assign fetch_idx        = fetch_pc[IDX_BITS+1:2];
  assign ex_idx           = ex_pc[IDX_BITS+1:2];
  assign unused_bits      = ^{fetch_pc[31:IDX_BITS+2], fetch_pc[1:0]};
  // Lookup reads the registered table, so a same-cycle update is not visible yet
  assign predict_taken    = fetch_valid & bht_q[fetch_idx][1];
  assign resolve          = (state_q == IDLE) && ex_valid && ex_is_branch;
  assign mispredict       = resolve && (should_branch != ex_pred_taken);
  assign redirect_valid   = redirect_valid_q;
  assign redirect_pc      = redirect_pc_q;
  assign flush            = state_q == FLUSH;
  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;
  always_comb begin
    upd_d              = should_branch ? (bht_q[ex_idx] == 2'd3 ? 2'd3 : bht_q[ex_idx] + 2'd1)
                                       : (bht_q[ex_idx] == 2'd0 ? 2'd0 : bht_q[ex_idx] - 2'd1);
    branch_count_d     = branch_count_q + {15'd0, resolve && branch_count_q != 16'hFFFF};
    mispredict_count_d = mispredict_count_q + {15'd0, mispredict && mispredict_count_q != 16'hFFFF};
    state_d            = state_q;
    flush_cnt_d        = flush_cnt_q;
    redirect_valid_d   = 1'b0;
    redirect_pc_d      = redirect_pc_q;
    if (state_q == FLUSH) begin
      flush_cnt_d = flush_cnt_q == 3'd0 ? 3'd0 : flush_cnt_q - 3'd1;
      state_d     = flush_cnt_q == 3'd0 ? IDLE : FLUSH;
    end else if (mispredict) begin
      state_d          = FLUSH;
      flush_cnt_d      = 3'(FLUSH_CYCLES - 1);
      redirect_valid_d = 1'b1;
      redirect_pc_d    = should_branch ? ex_target : ex_pc + 32'd4;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) bht_q[i] <= 2'b01;
      state_q            <= IDLE;
      flush_cnt_q        <= 3'd0;
      redirect_valid_q   <= 1'b0;
      redirect_pc_q      <= 32'd0;
      branch_count_q     <= 16'd0;
      mispredict_count_q <= 16'd0;
    end else begin
      if (resolve) bht_q[ex_idx] <= upd_d;
      state_q            <= state_d;
      flush_cnt_q        <= flush_cnt_d;
      redirect_valid_q   <= redirect_valid_d;
      redirect_pc_q      <= redirect_pc_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end
endmodule

// File: tb/tb_branch_predict_ctrl.sv
// tb_branch_predict_ctrl: directed and randomized checks of two predictor
// instances (flush length 2 and 4) against a behavioural model.
module tb_branch_predict_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic fetch_valid, ex_valid, ex_is_branch, ex_pred_taken, should_branch;
  logic [31:0] fetch_pc, ex_pc, ex_target;
  logic [1:0] pt, rv, fl;
  logic [1:0][31:0] rpc;
  logic [1:0][15:0] bc, mc;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  branch_predict_ctrl d0 (
    .clk(clk), .rst_n(rst_n), .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
    .predict_taken(pt[0]), .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
    .ex_pc(ex_pc), .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
    .should_branch(should_branch), .redirect_valid(rv[0]), .redirect_pc(rpc[0]),
    .flush(fl[0]), .branch_count(bc[0]), .mispredict_count(mc[0]));
  branch_predict_ctrl #(.FLUSH_CYCLES(4)) d1 (
    .clk(clk), .rst_n(rst_n), .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
    .predict_taken(pt[1]), .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
    .ex_pc(ex_pc), .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
    .should_branch(should_branch), .redirect_valid(rv[1]), .redirect_pc(rpc[1]),
    .flush(fl[1]), .branch_count(bc[1]), .mispredict_count(mc[1]));
  // Model: counters as ints, flush as "cycles still to squash"
  int m_bht [2][16];
  int m_left [2];
  int m_bc [2];
  int m_mc [2];
  bit m_rv [2];
  logic [31:0] m_rpc [2];
  bit started = 0;
  int e;
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        for (int j = 0; j < 16; j++) m_bht[k][j] = 1;
        m_left[k] = 0; m_bc[k] = 0; m_mc[k] = 0; m_rv[k] = 0; m_rpc[k] = 0;
        started = 1;
      end else begin
        m_rv[k] = 0;
        if (m_left[k] > 0) m_left[k] = m_left[k] - 1;
        else if (ex_valid && ex_is_branch) begin
          e = (ex_pc >> 2) % 16;
          m_bc[k] = m_bc[k] < 65535 ? m_bc[k] + 1 : 65535;
          m_bht[k][e] = should_branch ? (m_bht[k][e] < 3 ? m_bht[k][e] + 1 : 3)
                                      : (m_bht[k][e] > 0 ? m_bht[k][e] - 1 : 0);
          if (should_branch != ex_pred_taken) begin
            m_mc[k] = m_mc[k] < 65535 ? m_mc[k] + 1 : 65535;
            m_rv[k] = 1;
            m_rpc[k] = should_branch ? ex_target : ex_pc + 32'd4;
            m_left[k] = k ? 4 : 2;
          end
        end
      end
    end
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("predict_taken[%0d]", k), 32'(pt[k]),
              32'(fetch_valid && m_bht[k][(fetch_pc >> 2) % 16] >= 2));
        check($sformatf("redirect_valid[%0d]", k), 32'(rv[k]), 32'(m_rv[k]));
        check($sformatf("redirect_pc[%0d]", k), rpc[k], m_rpc[k]);
        check($sformatf("flush[%0d]", k), 32'(fl[k]), 32'(m_left[k] > 0));
        check($sformatf("branch_count[%0d]", k), 32'(bc[k]), m_bc[k]);
        check($sformatf("mispredict_count[%0d]", k), 32'(mc[k]), m_mc[k]);
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    ex_valid = 0; ex_is_branch = 0; ex_pred_taken = 0; should_branch = 0;
    ex_pc = 0; ex_target = 0;
  endtask
  task automatic resolve(input logic [31:0] pc, input logic [31:0] tgt, input logic pred, input logic sb);
    ex_valid = 1; ex_is_branch = 1; ex_pc = pc; ex_target = tgt;
    ex_pred_taken = pred; should_branch = sb;
  endtask
  task automatic do_reset();
    idle(); rst_n = 0; tick(); rst_n = 1;
  endtask
  initial begin
    idle(); fetch_valid = 0; fetch_pc = 0;
    rst_n = 0; tick(); tick(); rst_n = 1;
    fetch_valid = 1; fetch_pc = 32'h100; #1;
    check("t1 predict", 32'(pt[0]), 0);
    check("t1 redirect_valid", 32'(rv[0]), 0);
    check("t1 flush", 32'(fl[0]), 0);
    check("t1 branch_count", 32'(bc[0]), 0);
    check("t1 mispredict_count", 32'(mc[0]), 0);
    fetch_valid = 0;
    resolve(32'h200, 32'h180, 0, 1); tick();
    check("t2 redirect_valid", 32'(rv[0]), 1);
    check("t2 redirect_pc", rpc[0], 32'h180);
    check("t2 flush", 32'(fl[0]), 1);
    check("t2 branch_count", 32'(bc[0]), 1);
    check("t2 mispredict_count", 32'(mc[0]), 1);
    resolve(32'h300, 32'h500, 1, 0); tick();
    check("t2 pulse ends", 32'(rv[0]), 0);
    check("t2 flush cycle 2", 32'(fl[0]), 1);
    check("t2 ignored branch_count", 32'(bc[0]), 1);
    check("t2 ignored mispredict_count", 32'(mc[0]), 1);
    idle(); tick();
    check("t2 flush done", 32'(fl[0]), 0);
    check("t2 long flush", 32'(fl[1]), 1);
    tick(); tick();
    check("t2 long flush done", 32'(fl[1]), 0);
    do_reset();
    fetch_valid = 1; fetch_pc = 32'h40;
    resolve(32'h40, 32'h1000, 0, 1); #1;
    check("t5 collision old value", 32'(pt[0]), 0);
    tick();
    check("t5 updated value", 32'(pt[0]), 1);
    idle(); repeat (4) tick();
    resolve(32'h40, 32'h1000, 1, 1); tick(); tick();
    fetch_pc = 32'h80; #1;
    check("t3 alias taken", 32'(pt[0]), 1);
    check("t3 correct no redirect", 32'(rv[0]), 0);
    resolve(32'h40, 32'h1000, 1, 0); tick();
    check("t3 sat 3->2 still taken", 32'(pt[0]), 1);
    idle(); repeat (4) tick();
    resolve(32'h40, 32'h1000, 0, 0); tick();
    check("t3 2->1 not taken", 32'(pt[0]), 0);
    idle(); tick();
    resolve(32'hFFFF_FFFC, 32'h1234, 1, 0); tick();
    check("t4 wrap redirect_valid", 32'(rv[0]), 1);
    check("t4 wrap redirect_pc", rpc[0], 32'h0);
    idle(); repeat (4) tick();
    resolve(32'h10, 32'h20, 0, 1); tick();
    idle(); tick();
    check("t6 in 2nd flush cycle", 32'(fl[1]), 1);
    rst_n = 0; tick();
    check("t6 flush aborted", 32'(fl[1]), 0);
    rst_n = 1;
    resolve(32'h10, 32'h20, 0, 1); tick();
    check("t6 idle after reset", 32'(rv[1]), 1);
    idle(); repeat (4) tick();
    force d0.branch_count_q = 16'hFFFF;
    force d0.mispredict_count_q = 16'hFFFF;
    m_bc[0] = 65535; m_mc[0] = 65535;
    tick();
    release d0.branch_count_q;
    release d0.mispredict_count_q;
    resolve(32'h44, 32'h88, 0, 1); tick();
    check("t6 branch_count saturated", 32'(bc[0]), 32'hFFFF);
    check("t6 mispredict_count saturated", 32'(mc[0]), 32'hFFFF);
    idle(); repeat (4) tick();
    for (int i = 0; i < 4000; i++) begin
      rst_n = $urandom_range(0, 299) != 0;
      fetch_valid = $urandom_range(0, 1) == 1;
      fetch_pc = $urandom_range(0, 9) == 0 ? $urandom : ($urandom & 32'hFC);
      ex_valid = $urandom_range(0, 3) != 0;
      ex_is_branch = $urandom_range(0, 3) != 0;
      ex_pc = $urandom_range(0, 19) == 0 ? 32'hFFFF_FFFC : ($urandom & 32'hFC);
      ex_target = $urandom;
      ex_pred_taken = $urandom_range(0, 1) == 1;
      should_branch = $urandom_range(0, 2) != 0;
      tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
